gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_port.sv | 178 +++++++++++++++++
 tb/tb_gpio_port.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// gpio_port: 32-pin bidirectional GPIO block with a memory-mapped register file,
// per-pin input synchronizers, sticky edge capture and a level interrupt.
// All per-pin state lives in gpio_bit. The top level holds the address decode,
// the read mux, the post-reset edge mask and the irq flop.

// gpio_bit: one pin's OUT/DIR/IE bits, 2-flop synchronizer, IN_prev flop and sticky EDGE
module gpio_bit #(
    parameter logic RST_OUT = 1'b0,
    parameter logic RST_DIR = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    input  logic arm,
    input  logic wd,
    input  logic wr_out,
    input  logic wr_dir,
    input  logic wr_set,
    input  logic wr_clr,
    input  logic wr_w1c,
    input  logic wr_ie,
    output logic out_q,
    output logic dir_q,
    output logic in_q,
    output logic edge_q,
    output logic ie_q,
    output logic edge_nxt,
    output logic ie_nxt
);
    logic s1_q;
    logic prev_q;
    logic out_nxt;
    logic dir_nxt;
    logic edge_det;

    // Next-state for the software-visible bits; a detected edge beats a same-cycle W1C
    always_comb begin
        out_nxt  = out_q;
        dir_nxt  = dir_q;
        edge_det = (in_q ^ prev_q) & arm;
        if (wr_out) out_nxt = wd;
        if (wr_set) out_nxt = out_q | wd;
        if (wr_clr) out_nxt = out_q & ~wd;
        if (wr_dir) dir_nxt = wd;
        ie_nxt   = wr_ie ? wd : ie_q;
        edge_nxt = (edge_q & ~(wr_w1c & wd)) | edge_det;
    end

    // Register bits, synchronizer stages and edge history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= RST_OUT;
            dir_q  <= RST_DIR;
            ie_q   <= 1'b0;
            edge_q <= 1'b0;
            s1_q   <= 1'b0;
            in_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            out_q  <= out_nxt;
            dir_q  <= dir_nxt;
            ie_q   <= ie_nxt;
            edge_q <= edge_nxt;
            s1_q   <= pin_in;
            in_q   <= s1_q;
            prev_q <= in_q;
        end
    end
endmodule

module gpio_port #(
    parameter logic [31:0] RESET_OUT = 32'h0000_0000,
    parameter logic [31:0] RESET_DIR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    inout  wire  [31:0] gpio,
    output logic        irq
);
    localparam int NUM_LANES  = 32;
    localparam int ARM_STAGES = 3;

    logic [NUM_LANES-1:0] out_q;
    logic [NUM_LANES-1:0] dir_q;
    logic [NUM_LANES-1:0] in_q;
    logic [NUM_LANES-1:0] edge_q;
    logic [NUM_LANES-1:0] ie_q;
    logic [NUM_LANES-1:0] edge_nxt;
    logic [NUM_LANES-1:0] ie_nxt;
    logic [31:0]          rd_mux;

    // After reset the synchronizer refills from 0 and may see a phantom transition;
    // edge capture stays masked until the refill (3 clocks) has completed.
    logic [ARM_STAGES-1:0] arm_pipe;
    logic                  arm;

    logic wr_out;
    logic wr_dir;
    logic wr_w1c;
    logic wr_ie;
    logic wr_set;
    logic wr_clr;

    assign wr_out = we && (addr == 4'd0);
    assign wr_dir = we && (addr == 4'd1);
    assign wr_w1c = we && (addr == 4'd3);
    assign wr_ie  = we && (addr == 4'd4);
    assign wr_set = we && (addr == 4'd5);
    assign wr_clr = we && (addr == 4'd6);
    assign arm    = arm_pipe[ARM_STAGES-1];

    // Shift a 1 through the arm pipe after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) arm_pipe <= '0;
        else      arm_pipe <= {arm_pipe[ARM_STAGES-2:0], 1'b1};
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            gpio_bit #(
                .RST_OUT (RESET_OUT[i]),
                .RST_DIR (RESET_DIR[i])
            ) u_bit (
                .clk      (clk),
                .rst      (rst),
                .pin_in   (gpio[i]),
                .arm      (arm),
                .wd       (wdata[i]),
                .wr_out   (wr_out),
                .wr_dir   (wr_dir),
                .wr_set   (wr_set),
                .wr_clr   (wr_clr),
                .wr_w1c   (wr_w1c),
                .wr_ie    (wr_ie),
                .out_q    (out_q[i]),
                .dir_q    (dir_q[i]),
                .in_q     (in_q[i]),
                .edge_q   (edge_q[i]),
                .ie_q     (ie_q[i]),
                .edge_nxt (edge_nxt[i]),
                .ie_nxt   (ie_nxt[i])
            );
            // Pins are driven straight from the OUT/DIR flops; the synchronizer reads back
            // the pin itself, so driven pins loop back into IN.
            assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
        end
    endgenerate

    // Read mux over current register values; SET/CLR and reserved offsets read as 0
    always_comb begin
        rd_mux = '0;
        case (addr)
            4'd0:    rd_mux = out_q;
            4'd1:    rd_mux = dir_q;
            4'd2:    rd_mux = in_q;
            4'd3:    rd_mux = edge_q;
            4'd4:    rd_mux = ie_q;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data (held between reads) and level interrupt from next-state bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            if (re) rdata <= rd_mux;
            irq <= |(edge_nxt & ie_nxt);
        end
    end
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: randomized and directed checks of gpio_port against a
// cycle-level reference model kept in the bench.
module tb_gpio_port;
    localparam logic [31:0] RST_OUT = 32'hDEAD_0001;
    localparam logic [31:0] RST_DIR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        irq;
    wire  [31:0] gpio;

    logic [31:0] ext_oe = '0;
    logic [31:0] ext_val = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_out, m_dir, m_ie, m_edge, m_rdata;
    logic        m_irq;
    logic [31:0] hist [3];   // pin samples: [0] newest, [1] = IN, [2] = IN one cycle earlier
    int          m_cnt;      // clock edges seen since reset release (saturating)

    gpio_port #(.RESET_OUT(RST_OUT), .RESET_DIR(RST_DIR)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .gpio  (gpio),
        .irq   (irq)
    );

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_ext
            assign gpio[g] = ext_oe[g] ? ext_val[g] : 1'bz;
        end
    endgenerate

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_pins();
        return (m_dir & m_out) | (~m_dir & ext_val);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return m_out;
            4'd1: return m_dir;
            4'd2: return hist[1];
            4'd3: return m_edge;
            4'd4: return m_ie;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = RST_OUT; m_dir = RST_DIR; m_ie = '0; m_edge = '0;
        m_rdata = '0; m_irq = 1'b0; m_cnt = 0;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        ext_oe = ~RST_DIR;
    endtask

    // One bus cycle: drive at the negedge, advance the model across the posedge,
    // end at the following negedge. The bench only drives pins the DUT releases.
    task automatic step(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
        logic [31:0] pin, det, n_out, n_dir, n_ie, n_edge, n_rd;
        we = w; re = r; addr = a; wdata = d;
        pin    = exp_pins();
        det    = (m_cnt >= 3) ? (hist[1] ^ hist[2]) : 32'h0;
        n_out  = m_out; n_dir = m_dir; n_ie = m_ie; n_edge = m_edge;
        n_rd   = r ? m_read(a) : m_rdata;
        if (w) begin
            case (a)
                4'd0: n_out  = d;
                4'd1: n_dir  = d;
                4'd3: n_edge = m_edge & ~d;
                4'd4: n_ie   = d;
                4'd5: n_out  = m_out | d;
                4'd6: n_out  = m_out & ~d;
                default: ;
            endcase
        end
        n_edge = n_edge | det;
        @(posedge clk);
        m_out = n_out; m_dir = n_dir; m_ie = n_ie; m_edge = n_edge; m_rdata = n_rd;
        m_irq = |(n_edge & n_ie);
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pin;
        if (m_cnt < 3) m_cnt++;
        #1 ext_oe = ~m_dir;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset();
        ext_val = $urandom;
        ext_oe  = ~RST_DIR;
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (gpio !== ext_val) begin errors++; $display("FAIL reset_pins got=%h exp=%h", gpio, ext_val); end
        rst = 1'b1;
        step(1'b0, 1'b1, 4'd0, 32'h0);
        checks++; if (rdata !== RST_OUT) begin errors++; $display("FAIL reset_out got=%h exp=%h", rdata, RST_OUT); end
        for (int a = 1; a < 16; a++) begin
            step(1'b0, 1'b1, 4'(a), 32'h0);
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL reset_read%0d got=%h exp=%h", a, rdata, m_rdata); end
        end
        step(1'b0, 1'b1, 4'd3, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_no_edge got=%h exp=0", rdata); end
    endtask

    task automatic test_loopback();
        ext_val = $urandom;
        step(1'b1, 1'b0, 4'd1, 32'h0000_00FF);
        step(1'b1, 1'b0, 4'd0, 32'h0000_00A5);
        checks++; if (gpio[7:0] !== 8'hA5) begin errors++; $display("FAIL loop_pins got=%h exp=a5", gpio[7:0]); end
        checks++; if (gpio !== exp_pins()) begin errors++; $display("FAIL loop_allpins got=%h exp=%h", gpio, exp_pins()); end
        step(1'b0, 1'b0, 4'd0, 32'h0);
        step(1'b0, 1'b0, 4'd0, 32'h0);
        step(1'b0, 1'b1, 4'd2, 32'h0);
        checks++; if (rdata[7:0] !== 8'hA5) begin errors++; $display("FAIL loop_in got=%h exp=a5", rdata[7:0]); end
        checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL loop_in_word got=%h exp=%h", rdata, m_rdata); end
    endtask

    task automatic test_set_clr();
        step(1'b1, 1'b0, 4'd0, 32'h0000_000F);
        step(1'b1, 1'b0, 4'd5, 32'h0000_00F0);
        step(1'b1, 1'b0, 4'd6, 32'h0000_0003);
        step(1'b0, 1'b1, 4'd0, 32'h0);
        checks++; if (rdata !== 32'h0000_00FC) begin errors++; $display("FAIL set_clr got=%h exp=000000fc", rdata); end
        step(1'b0, 1'b1, 4'd5, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL set_reads_zero got=%h exp=0", rdata); end
    endtask

    task automatic test_edge_irq();
        step(1'b1, 1'b0, 4'd1, 32'h0);
        ext_val = 32'h0;
        repeat (4) step(1'b0, 1'b0, 4'd0, 32'h0);
        step(1'b1, 1'b0, 4'd3, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 4'd4, 32'h0000_0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_idle_irq got=%b exp=0", irq); end
        ext_val[0] = 1'b1;
        repeat (3) step(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq_set got=%b exp=1", irq); end
        step(1'b0, 1'b1, 4'd3, 32'h0);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL edge_reg got=%h exp=1", rdata); end
        step(1'b1, 1'b0, 4'd3, 32'h0000_0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_w1c_irq got=%b exp=0", irq); end
        step(1'b0, 1'b1, 4'd3, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL edge_w1c got=%h exp=0", rdata); end
    endtask

    task automatic test_w1c_race();
        step(1'b1, 1'b0, 4'd4, 32'h0000_0010);
        ext_val[4] = ~ext_val[4];
        repeat (3) step(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_pre_irq got=%b exp=1", irq); end
        ext_val[4] = ~ext_val[4];
        repeat (2) step(1'b0, 1'b0, 4'd0, 32'h0);
        step(1'b1, 1'b0, 4'd3, 32'h0000_0010);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq got=%b exp=1", irq); end
        step(1'b0, 1'b1, 4'd3, 32'h0);
        checks++; if (rdata[4] !== 1'b1) begin errors++; $display("FAIL race_edge4 got=%b exp=1", rdata[4]); end
        step(1'b1, 1'b0, 4'd3, 32'h0000_0010);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_clear_irq got=%b exp=0", irq); end
    endtask

    task automatic test_rw_same();
        step(1'b1, 1'b0, 4'd0, 32'h0000_0001);
        step(1'b1, 1'b1, 4'd0, 32'h0000_0002);
        checks++; if (rdata !== 32'h0000_0001) begin errors++; $display("FAIL rw_old got=%h exp=00000001", rdata); end
        step(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (rdata !== 32'h0000_0001) begin errors++; $display("FAIL rw_hold got=%h exp=00000001", rdata); end
        step(1'b0, 1'b1, 4'd0, 32'h0);
        checks++; if (rdata !== 32'h0000_0002) begin errors++; $display("FAIL rw_new got=%h exp=00000002", rdata); end
        step(1'b1, 1'b0, 4'd2, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 4'd9, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 4'd0, 32'h0);
        checks++; if (rdata !== 32'h0000_0002) begin errors++; $display("FAIL ignored_wr got=%h exp=00000002", rdata); end
    endtask

    task automatic test_random();
        logic [3:0]  a;
        logic [31:0] d;
        logic        w, r;
        for (int n = 0; n < 400; n++) begin
            ext_val = ext_val ^ ($urandom & $urandom & $urandom);
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            step(w, r, a, d);
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, rdata, m_rdata); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
            checks++; if (gpio !== exp_pins()) begin errors++; $display("FAIL rand_pins n=%0d got=%h exp=%h", n, gpio, exp_pins()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pat;
        step(1'b1, 1'b0, 4'd4, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 4'd1, 32'hFFFF_FFFF);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 4'd0, $urandom);
        step(1'b0, 1'b1, 4'd0, 32'h0);
        pat = 32'h5A5A_0F0F;
        we = 1'b1; re = 1'b1; addr = 4'd0; wdata = 32'hFFFF_FFFF;
        #2;
        rst = 1'b0;
        ext_val = pat;
        model_reset();
        #1;
        checks++; if (gpio !== pat) begin errors++; $display("FAIL rstmid_pins got=%h exp=%h", gpio, pat); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", rdata); end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        rst = 1'b1;
        repeat (5) step(1'b0, 1'b0, 4'd0, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_post_irq got=%b exp=0", irq); end
        step(1'b0, 1'b1, 4'd3, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_edge got=%h exp=0", rdata); end
        step(1'b0, 1'b1, 4'd0, 32'h0);
        checks++; if (rdata !== RST_OUT) begin errors++; $display("FAIL rstmid_out got=%h exp=%h", rdata, RST_OUT); end
        step(1'b0, 1'b1, 4'd2, 32'h0);
        checks++; if (rdata !== pat) begin errors++; $display("FAIL rstmid_in got=%h exp=%h", rdata, pat); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_set_clr();
        test_edge_irq();
        test_w1c_race();
        test_rw_same();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
